// File: rtl/gen_stagger_seq.sv
// gen_stagger_seq: staggered per-lane event sequencer with timestamped event report
module gen_stagger_seq #(
    parameter int NUM_LANES = 5,
    parameter int STEP = 10,
    parameter int TIMEOUT = 1000,
    parameter int TW = $clog2(TIMEOUT + 1),
    parameter int LW = (NUM_LANES > 1 ? $clog2(NUM_LANES) : 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 start_pulse,
    output logic                 finish_pulse,
    output logic [NUM_LANES-1:0] lane_pulse,
    output logic [NUM_LANES-1:0] lane_done,
    output logic                 evt_valid,
    output logic [LW-1:0]        evt_lane,
    output logic [TW-1:0]        evt_time,
    output logic [TW-1:0]        cur_time
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [TW-1:0] nt, time_n, etime_n;
    logic [NUM_LANES-1:0] hit, pulse_n, done_n;
    logic go, adv, start_n, finish_n, valid_n;
    logic [LW-1:0] lane_n;
    if (NUM_LANES < 1 || NUM_LANES > 32 || STEP < 1 || TIMEOUT <= (NUM_LANES - 1) * STEP) begin : g_bad
        $fatal(1, "gen_stagger_seq: illegal NUM_LANES/STEP/TIMEOUT combination");
    end
    // go launches a run from idle; adv advances a live run by one cycle
    assign go  = (state == IDLE) && start;
    assign adv = (state == RUN) && !abort && (cur_time != TW'(TIMEOUT));
    assign nt  = (state == IDLE) ? '0 : cur_time + TW'(1);
    assign busy = (state == RUN);
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign hit[g]    = (nt == TW'(g * STEP));
        assign done_n[g] = go ? hit[g] : (adv ? (lane_done[g] | hit[g]) : lane_done[g]);
    end
    // next state, next timestamp and next pulse/report values
    always_comb begin
        state_n  = state;
        lane_n   = '0;
        time_n   = (go || adv) ? nt : cur_time;
        start_n  = go;
        finish_n = adv && (nt == TW'(TIMEOUT));
        pulse_n  = (go || adv) ? hit : '0;
        valid_n  = |pulse_n;
        etime_n  = valid_n ? time_n : '0;
        if (go)
            state_n = RUN;
        else if (state == RUN && (abort || cur_time == TW'(TIMEOUT)))
            state_n = IDLE;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (pulse_n[i]) lane_n = LW'(i);
    end
    // register state and every output
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_time     <= '0;
            start_pulse  <= 1'b0;
            finish_pulse <= 1'b0;
            lane_pulse   <= '0;
            lane_done    <= '0;
            evt_valid    <= 1'b0;
            evt_lane     <= '0;
            evt_time     <= '0;
        end else begin
            state        <= state_n;
            cur_time     <= time_n;
            start_pulse  <= start_n;
            finish_pulse <= finish_n;
            lane_pulse   <= pulse_n;
            lane_done    <= done_n;
            evt_valid    <= valid_n;
            evt_lane     <= lane_n;
            evt_time     <= etime_n;
        end
    end
endmodule

// File: tb/tb_gen_stagger_seq.sv
// tb_gen_stagger_seq: model-checked bench for gen_stagger_seq plus a tiny-parameter instance
module tb_gen_stagger_seq;
    localparam int N = 5, S = 10, T = 1000, TW = 10, LW = 3;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic busy, start_pulse, finish_pulse, evt_valid;
    logic [N-1:0] lane_pulse, lane_done;
    logic [LW-1:0] evt_lane;
    logic [TW-1:0] evt_time, cur_time;
    logic b_start = 1'b0, b_abort = 1'b0;
    logic b_busy, b_sp, b_fp, b_valid;
    logic [0:0] b_pulse, b_done, b_lane;
    logic [1:0] b_etime, b_cur;
    int checks = 0, passed = 0, cyc = 0, sp_cnt = 0, fp_cnt = 0;
    bit run_chk = 0;
    bit m_busy;
    int m_t;
    logic [N-1:0] m_done;

    gen_stagger_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .start_pulse(start_pulse), .finish_pulse(finish_pulse), .lane_pulse(lane_pulse),
        .lane_done(lane_done), .evt_valid(evt_valid), .evt_lane(evt_lane),
        .evt_time(evt_time), .cur_time(cur_time)
    );

    gen_stagger_seq #(.NUM_LANES(1), .STEP(1), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy),
        .start_pulse(b_sp), .finish_pulse(b_fp), .lane_pulse(b_pulse),
        .lane_done(b_done), .evt_valid(b_valid), .evt_lane(b_lane),
        .evt_time(b_etime), .cur_time(b_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // run-level model: a run is just a clock t counting 0..T; lane k fires when t == k*S
    always @(posedge clk) begin : model
        bit b;
        int t;
        logic [N-1:0] d;
        cyc <= cyc + 1;
        b = m_busy; t = m_t; d = m_done;
        if (rst) begin b = 0; t = 0; d = '0; end
        else if (!b) begin if (start) begin b = 1; t = 0; d = '0; end end
        else if (abort || t == T) b = 0;
        else t = t + 1;
        if (b && t % S == 0 && t / S < N) d[t / S] = 1'b1;
        m_busy <= b; m_t <= t; m_done <= d;
    end

    // compare every output against the model each cycle
    always @(negedge clk) begin : compare
        bit fires;
        logic [N-1:0] ep;
        if (run_chk) begin
            fires = m_busy && (m_t % S == 0) && (m_t / S < N);
            ep = '0;
            if (fires) ep[m_t / S] = 1'b1;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("cur_time", 32'(cur_time), 32'(m_t));
            chk("start_pulse", 32'(start_pulse), 32'(m_busy && m_t == 0));
            chk("finish_pulse", 32'(finish_pulse), 32'(m_busy && m_t == T));
            chk("lane_pulse", 32'(lane_pulse), 32'(ep));
            chk("lane_done", 32'(lane_done), 32'(m_done));
            chk("evt_valid", 32'(evt_valid), 32'(fires));
            chk("evt_lane", 32'(evt_lane), fires ? 32'(m_t / S) : 32'd0);
            chk("evt_time", 32'(evt_time), fires ? 32'(m_t) : 32'd0);
            sp_cnt <= sp_cnt + int'(start_pulse);
            fp_cnt <= fp_cnt + int'(finish_pulse);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_t(input int t);
        int n = 0;
        while (!(busy && cur_time == TW'(t)) && n < 2000) begin tick(); n++; end
        chk($sformatf("reach time %0d", t), 32'(busy && cur_time == TW'(t)), 32'd1);
    endtask

    task automatic wait_sp(output int at);
        int n = 0;
        while (start_pulse !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("start_pulse seen", 32'(start_pulse), 32'd1);
        at = cyc;
    endtask

    initial begin : guard
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s0, f0, c0, c1, c2;
        repeat (2) tick();
        rst = 1'b0;
        run_chk = 1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset lane_done", 32'(lane_done), 32'd0);
        chk("reset cur_time", 32'(cur_time), 32'd0);
        // full default run
        start = 1'b1; tick(); start = 1'b0;
        chk("t1 start_pulse", 32'(start_pulse), 32'd1);
        chk("t1 cur_time", 32'(cur_time), 32'd0);
        chk("t1 lane0", 32'(lane_pulse), 32'b00001);
        wait_t(40);
        chk("t1 evt_lane 4", 32'(evt_lane), 32'd4);
        chk("t1 evt_time 40", 32'(evt_time), 32'd40);
        wait_t(1000);
        chk("t1 finish", 32'(finish_pulse), 32'd1);
        tick();
        chk("t1 idle", 32'(busy), 32'd0);
        chk("t1 hold time", 32'(cur_time), 32'd1000);
        chk("t1 lane_done", 32'(lane_done), 32'h1f);
        // reset mid-run
        start = 1'b1; tick(); start = 1'b0;
        wait_t(25);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t2 busy", 32'(busy), 32'd0);
        chk("t2 lane_done", 32'(lane_done), 32'd0);
        repeat (30) tick();
        // start requests while busy are ignored
        #1; s0 = sp_cnt; f0 = fp_cnt;
        @(negedge clk);
        start = 1'b1; tick(); start = 1'b0;
        wait_t(5);
        start = 1'b1; tick(); start = 1'b0;
        wait_t(999);
        start = 1'b1; tick();
        chk("t3 finish", 32'(finish_pulse), 32'd1);
        tick(); start = 1'b0;
        chk("t3 idle after finish", 32'(busy), 32'd0);
        tick(); #1;
        chk("t3 one start_pulse", 32'(sp_cnt - s0), 32'd1);
        chk("t3 one finish_pulse", 32'(fp_cnt - f0), 32'd1);
        @(negedge clk);
        // abort, with start also high so abort must win
        start = 1'b1; tick(); start = 1'b0;
        wait_t(16);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 cur_time", 32'(cur_time), 32'd16);
        chk("t4 lane_done", 32'(lane_done), 32'b00011);
        repeat (3) tick();
        chk("t4 time held", 32'(cur_time), 32'd16);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4 restart done", 32'(lane_done), 32'b00001);
        chk("t4 restart time", 32'(cur_time), 32'd0);
        wait_t(3);
        abort = 1'b1; tick(); abort = 1'b0;
        // continuous start
        start = 1'b1;
        wait_sp(c0); tick();
        wait_sp(c1); tick();
        wait_sp(c2);
        start = 1'b0;
        chk("t5 period a", 32'(c1 - c0), 32'd1002);
        chk("t5 period b", 32'(c2 - c1), 32'd1002);
        wait_t(1000);
        tick(); tick();
        // tiny instance: one lane, STEP 1, TIMEOUT 3
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b busy %0d", k), 32'(b_busy), 32'(k < 4));
            chk($sformatf("b cur_time %0d", k), 32'(b_cur), 32'(k < 4 ? k : 3));
            chk($sformatf("b start %0d", k), 32'(b_sp), 32'(k == 0));
            chk($sformatf("b finish %0d", k), 32'(b_fp), 32'(k == 3));
            chk($sformatf("b pulse %0d", k), 32'(b_pulse), 32'(k == 0));
            chk($sformatf("b valid %0d", k), 32'(b_valid), 32'(k == 0));
            chk($sformatf("b lane %0d", k), 32'(b_lane), 32'd0);
            chk($sformatf("b etime %0d", k), 32'(b_etime), 32'd0);
            chk($sformatf("b done %0d", k), 32'(b_done), 32'd1);
            tick();
        end
        run_chk = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
